// File: rtl/regfile_pkg.sv
// regfile_pkg: shared ABI register indices, reset defaults and data type for the register file.
package regfile_pkg;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA = 1;
  localparam int unsigned REG_SP = 2;
  localparam int unsigned REG_GP = 3;
  typedef logic [31:0] xlen_t;
  localparam xlen_t SP_RESET_DEF = 32'h7FFF_FFF0;
  localparam xlen_t GP_RESET_DEF = 32'h1000_0000;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register; flush clears, writeback clears, issue set wins over both.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR_PORTS = 1,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WR_PORTS-1:0]          wr_en_i,
  input  logic [NUM_WR_PORTS-1:0][AW-1:0]  wr_addr_i,
  input  logic                             busy_set_en_i,
  input  logic [AW-1:0]                    busy_set_addr_i,
  input  logic                             flush_i,
  output logic [NUM_REGS-1:0]              busy_o,
  output logic                             any_busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = flush_i ? '0 : busy_q;
    for (int p = 0; p < NUM_WR_PORTS; p++)
      if (wr_en_i[p]) busy_d[wr_addr_i[p]] = 1'b0;
    if (busy_set_en_i) busy_d[busy_set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_o = busy_q;
  assign any_busy_o = |busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port RISC-V integer register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(SP_RESET_DEF),
  parameter logic [XLEN-1:0] GP_RESET = XLEN'(GP_RESET_DEF),
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]    rd_addr_i,
  output logic [NUM_RD_PORTS-1:0][XLEN-1:0]  rd_data_o,
  output logic [NUM_RD_PORTS-1:0]            rd_busy_o,
  input  logic [NUM_WR_PORTS-1:0]            wr_en_i,
  input  logic [NUM_WR_PORTS-1:0][AW-1:0]    wr_addr_i,
  input  logic [NUM_WR_PORTS-1:0][XLEN-1:0]  wr_data_i,
  input  logic                               busy_set_en_i,
  input  logic [AW-1:0]                      busy_set_addr_i,
  input  logic                               flush_i,
  output logic                               any_busy_o
);
  logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0] busy;
  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_WR_PORTS(NUM_WR_PORTS), .AW(AW)) u_sb (
    .clk(clk),
    .rst(rst),
    .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i),
    .busy_set_en_i(busy_set_en_i),
    .busy_set_addr_i(busy_set_addr_i),
    .flush_i(flush_i),
    .busy_o(busy),
    .any_busy_o(any_busy_o)
  );
  // Ascending loop lets the highest-indexed port win a same-address collision.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WR_PORTS; p++)
      if (wr_en_i[p] && wr_addr_i[p] != '0) regs_d[wr_addr_i[p]] = wr_data_i[p];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regs_q <= '0;
      regs_q[REG_SP] <= SP_RESET;
      regs_q[REG_GP] <= GP_RESET;
    end else regs_q <= regs_d;
  always_comb begin
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      rd_data_o[i] = regs_q[rd_addr_i[i]];
      rd_busy_o[i] = busy[rd_addr_i[i]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR_PORTS; p++)
        if (wr_en_i[p] && wr_addr_i[p] == rd_addr_i[i] && rd_addr_i[i] != '0) begin
          rd_data_o[i] = wr_data_i[p];
          rd_busy_o[i] = busy_set_en_i && busy_set_addr_i == rd_addr_i[i];
        end
`endif
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table, bypass/reset sequences and randomized model comparison.
module tb_regfile_mp;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0][4:0] rd_addr = '0;
  logic [1:0][31:0] rd_data;
  logic [1:0] rd_busy;
  logic [1:0] wr_en = '0;
  logic [1:0][4:0] wr_addr = '0;
  logic [1:0][31:0] wr_data = '0;
  logic set_en = 1'b0, flush = 1'b0, any_busy;
  logic [4:0] set_addr = '0;
  int n_checks = 0, n_fail = 0;
  logic [31:0] m_regs [32];
  logic m_busy [32];

  regfile_mp #(.NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .busy_set_en_i(set_en),
    .busy_set_addr_i(set_addr), .flush_i(flush), .any_busy_o(any_busy)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] we; logic [4:0] wa0, wa1; logic [31:0] wd0, wd1;
    logic se; logic [4:0] sa; logic fl; logic [4:0] ra;
    logic [31:0] ed; logic eb, ea;
  } vec_t;
  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'h0;
      m_busy[r] = 1'b0;
    end
    m_regs[2] = 32'h7FFF_FFF0;
    m_regs[3] = 32'h1000_0000;
  endtask

  // Architectural effect of one clock edge.
  task automatic model_edge();
    logic any_wr [32];
    for (int r = 0; r < 32; r++) any_wr[r] = 1'b0;
    for (int p = 0; p < 2; p++)
      if (wr_en[p]) begin
        any_wr[wr_addr[p]] = 1'b1;
        if (wr_addr[p] != 0) m_regs[wr_addr[p]] = wr_data[p];
      end
    for (int r = 1; r < 32; r++)
      m_busy[r] = flush ? 1'b0 : (any_wr[r] ? 1'b0 : m_busy[r]);
    if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    logic [31:0] v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p] == a && a != 0) v = wr_data[p];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p] == a && a != 0) b = set_en && set_addr == a;
`endif
    return b;
  endfunction

  function automatic logic model_any();
    logic b = 1'b0;
    for (int r = 0; r < 32; r++) b |= m_busy[r];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    set_en = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    logic [4:0] rst_addr [4];
    logic [31:0] rst_exp [4];
    rst_addr = '{5'd0, 5'd2, 5'd3, 5'd5};
    rst_exp = '{32'h0, 32'h7FFF_FFF0, 32'h1000_0000, 32'h0};
    vecs[0]  = '{2'b01, 5'd10, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0, 1'b0, 5'd10, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 5'd7, 5'd7, 32'h1111, 32'h2222, 1'b0, 5'd0, 1'b0, 5'd7, 32'h2222, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 32'h0, 1'b1, 1'b1};
    vecs[4]  = '{2'b01, 5'd5, 5'd0, 32'h55, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 32'h55, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 5'd0, 5'd5, 32'h0, 32'h66, 1'b1, 5'd5, 1'b0, 5'd5, 32'h66, 1'b1, 1'b1};
    vecs[6]  = '{2'b01, 5'd5, 5'd0, 32'h77, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 32'h77, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd6, 32'h0, 1'b1, 1'b1};
    vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd6, 32'h0, 1'b1, 1'b1};
    vecs[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd6, 32'h0, 1'b0, 1'b1};
    vecs[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 32'h0, 1'b1, 1'b1};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 32'h0, 1'b0, 1'b1};
    vecs[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h0, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
    model_reset();
    #12;
    for (int k = 0; k < 4; k++) begin
      rd_addr[0] = rst_addr[k];
      #1;
      check("reset_rd_data", rd_data[0], rst_exp[k]);
      check("reset_rd_busy", {31'b0, rd_busy[0]}, 32'h0);
    end
    check("reset_any_busy", {31'b0, any_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      wr_en = vecs[k].we;
      wr_addr[0] = vecs[k].wa0;
      wr_addr[1] = vecs[k].wa1;
      wr_data[0] = vecs[k].wd0;
      wr_data[1] = vecs[k].wd1;
      set_en = vecs[k].se;
      set_addr = vecs[k].sa;
      flush = vecs[k].fl;
      tick();
      idle();
      rd_addr[0] = vecs[k].ra;
      rd_addr[1] = 5'd0;
      #1;
      check($sformatf("vec%0d_data", k), rd_data[0], vecs[k].ed);
      check($sformatf("vec%0d_busy", k), {31'b0, rd_busy[0]}, {31'b0, vecs[k].eb});
      check($sformatf("vec%0d_any", k), {31'b0, any_busy}, {31'b0, vecs[k].ea});
    end
    wr_en = 2'b01; wr_addr[0] = 5'd12; wr_data[0] = 32'h1234;
    tick();
    wr_data[0] = 32'hCAFE;
    rd_addr[0] = 5'd12;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_read", rd_data[0], 32'hCAFE);
`else
    check("same_cycle_read", rd_data[0], 32'h1234);
`endif
    tick();
    idle();
    #1;
    check("after_write_read", rd_data[0], 32'hCAFE);
    set_en = 1'b1; set_addr = 5'd8;
    tick();
    wr_en = 2'b01; wr_addr[0] = 5'd12; wr_data[0] = 32'hBEEF; set_addr = 5'd13;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    idle();
    rd_addr[0] = 5'd12;
    rd_addr[1] = 5'd2;
    #1;
    check("midreset_x12", rd_data[0], 32'h0);
    check("midreset_sp", rd_data[1], 32'h7FFF_FFF0);
    check("midreset_any_busy", {31'b0, any_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int it = 0; it < 300; it++) begin
      wr_en = 2'($urandom_range(0, 3));
      wr_addr[0] = 5'($urandom_range(0, 15));
      wr_addr[1] = 5'($urandom_range(0, 15));
      wr_data[0] = $urandom;
      wr_data[1] = $urandom;
      set_en = ($urandom_range(0, 2) == 0);
      set_addr = 5'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      rd_addr[0] = 5'($urandom_range(0, 15));
      rd_addr[1] = 5'($urandom_range(0, 31));
      #1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rand_data%0d", i), rd_data[i], exp_data(rd_addr[i]));
        check($sformatf("rand_busy%0d", i), {31'b0, rd_busy[i]}, {31'b0, exp_busy(rd_addr[i])});
      end
      check("rand_any_busy", {31'b0, any_busy}, {31'b0, model_any()});
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Clocked, parametrised multi-port RISC-V integer register file with an integrated busy-bit scoreboard.
- Sits between decode (read and issue side) and writeback, and replaces the combinational single-write register array.
- Storage updates on the clock edge. Reads are combinational, with optional same-cycle write forwarding.
- x0 is hardwired to zero. sp and gp come out of reset at their ABI values.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, architectural register count; power of two, at least 4.
- NUM_RD_PORTS, 2, number of read ports.
- NUM_WR_PORTS, 1, number of write ports; higher index has priority.
- SP_RESET, 32'h7FFF_FFF0, reset value of x2 (sp).
- GP_RESET, 32'h1000_0000, reset value of x3 (gp).

Ports (AW = $clog2(NUM_REGS)):
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset; asynchronous, active-high.
- rd_addr, in, NUM_RD_PORTS x AW, read addresses (rs1/rs2).
- rd_data, out, NUM_RD_PORTS x XLEN, read data.
- rd_busy, out, NUM_RD_PORTS, addressed register has a pending producer.
- wr_en, in, NUM_WR_PORTS, write strobes.
- wr_addr, in, NUM_WR_PORTS x AW, write addresses (rd).
- wr_data, in, NUM_WR_PORTS x XLEN, write data.
- busy_set_en, in, 1, issue stage claims a destination register.
- busy_set_addr, in, AW, register being claimed.
- flush, in, 1, synchronous clear of all busy bits.
- any_busy, out, 1, OR of all busy bits; registered-state derived.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all registers become 0, except x2 = SP_RESET and x3 = GP_RESET;
  - all busy bits become 0;
  - rd_busy = 0 and any_busy = 0.
  - rd_data reflects the reset contents combinationally.
  - Reset asserted mid-operation discards in-flight writes and busy state in the same instant.
- Write:
  - On a clk rising edge with wr_en[p]=1 and wr_addr[p]!=0, reg[wr_addr[p]] takes wr_data[p].
  - Writes to x0 are ignored.
  - Two ports writing the same address in the same cycle: the highest port index wins.
- Read:
  - rd_data[i] = reg[rd_addr[i]] combinationally, zero latency.
  - rd_addr = 0 always returns 0.
- Scoreboard (one busy bit per register; bit 0 is constant 0):
  - Set: busy_set_en=1 with busy_set_addr!=0 sets busy[busy_set_addr] at the edge.
  - Clear: any wr_en[p] with wr_addr[p]=a, a!=0, clears busy[a] at the edge.
  - Set and clear of the same address in one cycle: set wins, because the new producer supersedes the old one.
  - flush=1 clears every busy bit at the edge. It overrides clears but not a same-cycle set; the set is applied after the flush.
  - Setting an already-busy register keeps it busy. No counting; one outstanding producer per register is assumed by the issue logic.
  - rd_busy[i] = busy[rd_addr[i]], without forwarding (see Optional Feature).
  - any_busy = |busy.
- Width rules: addresses are exactly AW bits, so no out-of-range handling is needed. Data passes through unmodified with no sign extension.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If any wr_en[p]=1 with wr_addr[p]==rd_addr[i]!=0, rd_data[i] returns the winning wr_data[p] in the same cycle (highest matching p).
  - In that case rd_busy[i] is forced 0, unless busy_set_addr also matches with busy_set_en=1.
- Undefined: reads return stored contents only. A write becomes visible on the cycle after its edge. rd_busy shows the stored busy bit.

Decomposition:
- Package regfile_pkg holds:
  - ABI index constants: REG_ZERO=0, REG_RA=1, REG_SP=2, REG_GP=3;
  - default SP_RESET/GP_RESET localparams;
  - typedef xlen_t (logic [31:0]).
- Sub-module regfile_scoreboard (busy vector, set/clear/flush priority, any_busy) is natural. Storage, write priority and read muxing stay in regfile_mp.

Test Plan:
- Reset, then read x0/x2/x3/x5 -> 0, 32'h7FFF_FFF0, 32'h1000_0000, 0; any_busy=0.
- Write x10=32'hDEAD_BEEF; next cycle read port 0 addr 10 -> DEAD_BEEF. Write x0=32'hFFFF_FFFF -> x0 reads 0.
- NUM_WR_PORTS=2, both ports write x7 (port0=32'h1111, port1=32'h2222) -> x7=32'h2222.
- busy_set x5; next cycle rd_busy on addr 5 = 1. Write x5 -> busy clears the following cycle. Same-cycle set+write of x5 -> stays busy.
- busy_set x6 and x9, then flush=1 with busy_set x4 in the same cycle -> only busy[4]=1; any_busy=1.
- With REGFILE_BYPASS_EN: write x12=32'hCAFE while reading x12 the same cycle -> rd_data=32'hCAFE. Without it -> old value. Assert rst mid-write -> x12 reads 0.
